// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: default bubble encoding and skid-buffer state encoding.
package cpu_pipe_pkg;

  localparam int unsigned     NOP_W             = 32;
  localparam logic [NOP_W-1:0] NOP_INSTR_DEFAULT = 32'h0400_0000;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage : cpu_pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with two-entry skid buffer, flush bubble and sticky halt latch.
// Optional performance counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  input  logic               in_halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4,
  output logic               out_halt,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count
);

  skid_state_e        state, state_nx;
  logic [INSTR_W-1:0] main_instr_nx, skid_instr, skid_instr_nx;
  logic [PC_W-1:0]    main_pc4_nx, skid_pc4, skid_pc4_nx;
  logic               main_halt_nx, skid_halt, skid_halt_nx;
  logic               halted_nx;
  logic               accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // State, main (output) register, skid register and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SKID_EMPTY;
      out_valid  <= 1'b0;
      out_instr  <= NOP_INSTR;
      out_pc4    <= '0;
      out_halt   <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= '0;
      skid_halt  <= 1'b0;
      halted     <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_nx;
      out_valid  <= (state_nx != SKID_EMPTY);
      out_instr  <= main_instr_nx;
      out_pc4    <= main_pc4_nx;
      out_halt   <= main_halt_nx;
      skid_instr <= skid_instr_nx;
      skid_pc4   <= skid_pc4_nx;
      skid_halt  <= skid_halt_nx;
      halted     <= halted_nx;
      in_ready   <= (state_nx != SKID_FULL) && !halted_nx;
    end
  end

  // Next-state and datapath steering; flush overrides accept and pop.
  always_comb begin
    state_nx      = state;
    main_instr_nx = out_instr;
    main_pc4_nx   = out_pc4;
    main_halt_nx  = out_halt;
    skid_instr_nx = skid_instr;
    skid_pc4_nx   = skid_pc4;
    skid_halt_nx  = skid_halt;
    halted_nx     = halted || (accept && in_halt);

    if (flush) begin
      state_nx      = SKID_EMPTY;
      main_instr_nx = NOP_INSTR;
      main_pc4_nx   = '0;
      main_halt_nx  = 1'b0;
    end else begin
      unique case (state)
        SKID_EMPTY: begin
          if (accept) begin
            state_nx      = SKID_ONE;
            main_instr_nx = in_instr;
            main_pc4_nx   = in_pc4;
            main_halt_nx  = in_halt;
          end
        end
        SKID_ONE: begin
          if (accept && !pop) begin
            state_nx      = SKID_FULL;
            skid_instr_nx = in_instr;
            skid_pc4_nx   = in_pc4;
            skid_halt_nx  = in_halt;
          end else if (accept && pop) begin
            main_instr_nx = in_instr;
            main_pc4_nx   = in_pc4;
            main_halt_nx  = in_halt;
          end else if (pop) begin
            state_nx      = SKID_EMPTY;
            main_instr_nx = NOP_INSTR;
            main_pc4_nx   = '0;
            main_halt_nx  = 1'b0;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            state_nx      = SKID_ONE;
            main_instr_nx = skid_instr;
            main_pc4_nx   = skid_pc4;
            main_halt_nx  = skid_halt;
          end
        end
        default: begin
          state_nx      = SKID_EMPTY;
          main_instr_nx = NOP_INSTR;
          main_pc4_nx   = '0;
          main_halt_nx  = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  assign stall_inc = out_valid && !out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (counters sized to 4 bits to reach saturation).
module tb_pipe_stage_skid;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0400_0000;

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, in_ready, in_halt;
  logic               out_valid, out_ready, out_halt, halted;
  logic [INSTR_W-1:0] in_instr, out_instr;
  logic [PC_W-1:0]    in_pc4, out_pc4;
  logic [CNT_W-1:0]   stall_cycles, flush_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc4       (in_pc4),
    .in_halt      (in_halt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc4      (out_pc4),
    .out_halt     (out_halt),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic h);
    in_valid = v;
    in_instr = instr;
    in_pc4   = instr + 32'd4;
    in_halt  = h;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step(); step();
    rst = 1'b0;
  endtask

  logic [CNT_W-1:0] exp_stall2, exp_flush1, exp_sat;

  initial begin
`ifdef PIPE_STAGE_PERF_EN
    exp_stall2 = 4'd2; exp_flush1 = 4'd1; exp_sat = 4'd15;
`else
    exp_stall2 = 4'd0; exp_flush1 = 4'd0; exp_sat = 4'd0;
`endif
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'(NOP));
    check("rst_out_pc4",   64'(out_pc4), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_halted",    64'(halted), 64'd0);
    check("rst_stall",     64'(stall_cycles), 64'd0);
    check("rst_flushcnt",  64'(flush_count), 64'd0);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      step();
      check($sformatf("stream_instr_%0d", i), 64'(out_instr), 64'(i));
      check($sformatf("stream_pc4_%0d", i), 64'(out_pc4), 64'(i + 4));
      check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check("stream_drain_instr", 64'(out_instr), 64'(NOP));

    // Backpressure fills the skid.
    do_reset();
    drive(1'b1, 32'hA, 1'b0);
    step();
    check("bp_ready_one", 64'(in_ready), 64'd1);
    check("bp_instr_a0",  64'(out_instr), 64'hA);
    drive(1'b1, 32'hB, 1'b0);
    step();
    check("bp_ready_full", 64'(in_ready), 64'd0);
    check("bp_instr_a1",   64'(out_instr), 64'hA);
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("bp_instr_a2",  64'(out_instr), 64'hA);
    check("bp_ready_hold", 64'(in_ready), 64'd0);
    check("bp_stall_cnt",  64'(stall_cycles), 64'(exp_stall2));
    out_ready = 1'b1;
    step();
    check("bp_instr_b",   64'(out_instr), 64'hB);
    check("bp_ready_rise", 64'(in_ready), 64'd1);
    step();
    check("bp_drain_valid", 64'(out_valid), 64'd0);
    check("bp_stall_final", 64'(stall_cycles), 64'(exp_stall2));

    // Flush while full, with a beat offered.
    do_reset();
    drive(1'b1, 32'hA, 1'b0); step();
    drive(1'b1, 32'hB, 1'b0); step();
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    check("fl_valid",    64'(out_valid), 64'd0);
    check("fl_instr",    64'(out_instr), 64'(NOP));
    check("fl_halt",     64'(out_halt), 64'd0);
    check("fl_ready",    64'(in_ready), 64'd1);
    check("fl_count",    64'(flush_count), 64'(exp_flush1));
    out_ready = 1'b1;
    step();
    check("fl_no_c_valid", 64'(out_valid), 64'd0);
    check("fl_no_c_instr", 64'(out_instr), 64'(NOP));

    // Halt latch.
    do_reset();
    drive(1'b1, 32'h5, 1'b1);
    step();
    check("h_halted",   64'(halted), 64'd1);
    check("h_ready",    64'(in_ready), 64'd0);
    check("h_instr",    64'(out_instr), 64'h5);
    check("h_out_halt", 64'(out_halt), 64'd1);
    drive(1'b1, 32'h6, 1'b0);
    step();
    check("h_blocked", 64'(out_instr), 64'h5);
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("h_pop_valid", 64'(out_valid), 64'd0);
    check("h_pop_halt",  64'(out_halt), 64'd0);
    check("h_ready_off", 64'(in_ready), 64'd0);
    flush = 1'b1; step(); flush = 1'b0;
    check("h_after_flush", 64'(halted), 64'd1);
    check("h_ready_flush", 64'(in_ready), 64'd0);
    rst = 1'b1; step(); rst = 1'b0;
    check("h_rst_halted", 64'(halted), 64'd0);
    check("h_rst_ready",  64'(in_ready), 64'd1);

    // Counter saturation.
    do_reset();
    drive(1'b1, 32'h7, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0);
    repeat (20) step();
    check("sat_stall", 64'(stall_cycles), 64'(exp_sat));
    check("sat_hold_instr", 64'(out_instr), 64'h7);
    flush = 1'b1;
    repeat (17) step();
    flush = 1'b0;
    check("sat_flush", 64'(flush_count), 64'(exp_sat));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipe_stage_skid

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised successor to the fixed IF/ID pipeline register: a single pipeline stage carrying instruction, PC+4 and HALT with a valid/ready handshake instead of a global stall. A two-entry skid buffer keeps `in_ready` a pure register output while sustaining one beat per cycle. Flush discards all held beats and presents a NOP bubble. A sticky halt latch blocks intake after a HALT beat. Sits between any two CPU stages (IF/ID first, then ID/EX and later).

## Interface
- `INSTR_W`, 32, instruction width
- `PC_W`, 32, PC+4 width
- `NOP_INSTR`, 32'h0400_0000, bubble encoding (opcode 000001, remaining bits 0); width INSTR_W
- `CNT_W`, 16, performance counter width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  discard all held and incoming beats this cycle
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  INSTR_W  instruction
- `in_pc4`  in  PC_W  PC+4
- `in_halt`  in  1  HALT marker
- `out_valid`  out  1  downstream beat valid
- `out_ready`  in  1  downstream accepts
- `out_instr`  out  INSTR_W  instruction; NOP_INSTR when `out_valid`=0
- `out_pc4`  out  PC_W  PC+4; 0 when `out_valid`=0
- `out_halt`  out  1  HALT; 0 when `out_valid`=0
- `halted`  out  1  sticky halt latch
- `stall_cycles`  out  CNT_W  backpressure cycle count
- `flush_count`  out  CNT_W  flush cycle count

## Operation
- Accept = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Storage: main register (drives outputs) and skid register. States: EMPTY, ONE (main valid), FULL (main + skid valid).
- EMPTY: accept → ONE, main ← input.
- ONE: accept & !pop → FULL, skid ← input. Accept & pop → ONE, main ← input. !accept & pop → EMPTY.
- FULL: pop → ONE, main ← skid. Otherwise hold. No accept possible in FULL.
- `in_ready` = (state ≠ FULL) && !`halted`, computed from registered state.
- Flush: state → EMPTY, outputs → bubble values. An input beat presented with `in_ready`=1 in the flush cycle counts as accepted upstream and is discarded. Flush does not clear `halted`.
- Halt latch: set on accepting a beat with `in_halt`=1. That beat still flows through normally. Cleared only by `rst`.
- Held beats are never altered or reordered. Outputs are stable while `out_valid && !out_ready`.
- Flush has priority over accept and pop. `rst` has priority over everything.

## Timing
- Reset: state EMPTY, `out_valid`=0, `out_instr`=NOP_INSTR, `out_pc4`=0, `out_halt`=0, `in_ready`=1, `halted`=0, counters 0.
- Latency: beat accepted at edge N appears on outputs after edge N (1 cycle).
- Throughput: 1 beat per cycle with `out_ready` held high.
- `in_ready` falls the cycle after the skid fills. It rises the cycle after a pop from FULL.
- Flush at edge N: `out_valid`=0 after edge N. `in_ready` is 1 after edge N unless `halted`.
- `rst` mid-transfer drops all beats. No partial state survives.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cycles` increments each cycle with `out_valid && !out_ready`.
  - `flush_count` increments each cycle `flush`=1.
  - Both saturate at 2^CNT_W−1. Cleared by `rst` only.
- Undefined: counter logic is absent and both outputs are tied to 0.

## Structure
- Shared package `cpu_pipe_pkg`:
  - default `NOP_INSTR` constant
  - skid state enum (EMPTY/ONE/FULL)
- Sub-module `sat_counter` (CNT_W, inc, clear via rst), instantiated twice, only under `PIPE_STAGE_PERF_EN`.
- Flops use the codebase synchronous-reset dff style.

## Test plan
- Reset then idle → `out_valid`=0, `out_instr`=32'h0400_0000, `in_ready`=1, `halted`=0.
- Stream instr 0x1,0x2,0x3 with `out_ready`=1 → outputs 0x1,0x2,0x3 on consecutive cycles, one cycle after each accept, `in_ready` constantly 1.
- `out_ready`=0, push 0xA,0xB → `in_ready`=0 after the second accept, 0xA held stable. Release `out_ready` → 0xA then 0xB, `in_ready`=1 one cycle after the first pop. `stall_cycles` equals the stalled cycle count (with macro).
- FULL with 0xA,0xB, assert `flush` with `in_valid`=1, instr 0xC → next cycle `out_valid`=0, `out_instr`=NOP_INSTR, 0xC never appears, `flush_count`=1.
- Accept beat 0x5 with `in_halt`=1 → `halted`=1 and `in_ready`=0 next cycle. 0x5 exits with `out_halt`=1. Later flush leaves `halted`=1. `rst` clears it.
- Counter saturation with CNT_W=4: hold backpressure 20 cycles → `stall_cycles`=15. Without macro → both counters 0.
